// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: transfer-based SPI serial-clock generator for the APB SPI core.
// Produces SCLK plus one-cycle sample/shift strobes for the shift-register
// datapath, with a start/busy/done handshake, wait-mode freeze and stop abort.
// Optional build macro SPI_SCLK_GAP_EN: adds a GAP state of H cycles after
// TAIL, so back-to-back transfers always see a full idle SCLK period.
//
// state  | meaning
// IDLE   | sclk follows cpol, waiting for start
// ACTIVE | half-period counter running, sclk toggling
// FROZEN | wait mode with spiswai: counter, edge count and sclk held
// TAIL   | last edge done, holding cpol level for H cycles
// GAP    | (SPI_SCLK_GAP_EN only) extra H idle cycles before done
module spi_sclk_gen #(
  parameter int DIV_W    = 12,
  parameter int SPPR_W   = 3,
  parameter int SPR_W    = 3,
  parameter int MAX_BITS = 16,
  parameter int NB_W     = $clog2(MAX_BITS) + 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [1:0]        spi_mode,
  input  logic              spiswai,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [NB_W-1:0]   nbits,
  input  logic              start,
  output logic              sclk,
  output logic              busy,
  output logic              done,
  output logic              sample_strb,
  output logic              shift_strb,
  output logic [DIV_W-1:0]  BaudRateDivisor
);

  // Edge count reaches 2*MAX_BITS, one bit wider than nbits.
  localparam int EC_W   = NB_W + 1;
  // (sppr+1) needs SPPR_W+1 bits; the shift adds up to 2^SPR_W bits.
  localparam int FULL_W = SPPR_W + 1 + (1 << SPR_W);
  localparam int CW     = ((FULL_W > DIV_W) ? FULL_W : DIV_W) + 1;
  localparam logic [CW-1:0] BRD_SAT = (CW'(1) << DIV_W) - CW'(2);

`ifdef SPI_SCLK_GAP_EN
  typedef enum logic [2:0] {IDLE, ACTIVE, FROZEN, TAIL, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE, FROZEN, TAIL} state_t;
`endif

  state_t            state_q, state_d;
  logic [DIV_W-2:0]  cnt_q, cnt_d;
  logic [DIV_W-2:0]  hm1_q, hm1_d;
  logic [EC_W-1:0]   ec_q, ec_d;
  logic [EC_W-1:0]   e_q, e_d;
  logic              cpha_q, cpha_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sample_q, sample_d;
  logic              shift_q, shift_d;
  logic              rst_done_q;

  logic [SPR_W:0]    shamt;
  logic [CW-1:0]     brd_full;
  logic [DIV_W-2:0]  hm1_new;
  logic [EC_W-1:0]   e_new;
  logic [EC_W-1:0]   ec_nx;
  logic              stop_req;
  logic              freeze_req;
  logic              run_ok;

  // Divisor is computed wide so that large sppr/spr cannot wrap before saturation.
  assign shamt    = {1'b0, spr} + (SPR_W + 1)'(1);
  assign brd_full = (CW'(sppr) + CW'(1)) << shamt;
  assign BaudRateDivisor = (brd_full > BRD_SAT) ? BRD_SAT[DIV_W-1:0] : brd_full[DIV_W-1:0];

  assign hm1_new    = BaudRateDivisor[DIV_W-1:1] - (DIV_W - 1)'(1);
  assign e_new      = (nbits == '0) ? EC_W'(2 * MAX_BITS) : {nbits, 1'b0};
  assign ec_nx      = ec_q + EC_W'(1);
  assign stop_req   = spi_mode[1];
  assign freeze_req = (spi_mode == 2'b01) && spiswai;
  assign run_ok     = !stop_req && !freeze_req;

  // While reset is asserted sclk shows cpol directly, avoiding an async load of an input.
  assign sclk        = rst_done_q ? sclk_q : cpol;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_strb = sample_q;
  assign shift_strb  = shift_q;

  // State and datapath registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hm1_q      <= '0;
      ec_q       <= '0;
      e_q        <= '0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hm1_q      <= hm1_d;
      ec_q       <= ec_d;
      e_q        <= e_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      rst_done_q <= 1'b1;
    end
  end

  // Next-state, counters and registered strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hm1_d    = hm1_q;
    ec_d     = ec_q;
    e_d      = e_q;
    cpha_d   = cpha_q;
    sclk_d   = sclk_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sample_d = 1'b0;
    shift_d  = 1'b0;

    if (state_q != IDLE && stop_req) begin
      state_d = IDLE;
      sclk_d  = cpol;
      busy_d  = 1'b0;
      cnt_d   = '0;
      ec_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_d = cpol;
          busy_d = 1'b0;
          cnt_d  = '0;
          ec_d   = '0;
          if (start && run_ok) begin
            state_d = ACTIVE;
            busy_d  = 1'b1;
            hm1_d   = hm1_new;
            e_d     = e_new;
            cpha_d  = cpha;
          end
        end
        // A resume cycle counts normally, so a freeze of N cycles delays by exactly N.
        ACTIVE, FROZEN: begin
          if (freeze_req) begin
            state_d = FROZEN;
          end else begin
            state_d = ACTIVE;
            if (cnt_q == hm1_q) begin
              cnt_d  = '0;
              sclk_d = ~sclk_q;
              ec_d   = ec_nx;
              // Odd edge numbers are leading edges; cpha swaps the strobe roles.
              if (ec_nx[0] ^ cpha_q) sample_d = 1'b1;
              else                   shift_d  = 1'b1;
              if (ec_nx == e_q) state_d = TAIL;
            end else begin
              cnt_d = cnt_q + (DIV_W - 1)'(1);
            end
          end
        end
        TAIL: begin
          if (cnt_q == hm1_q) begin
            cnt_d = '0;
`ifdef SPI_SCLK_GAP_EN
            state_d = GAP;
`else
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + (DIV_W - 1)'(1);
          end
        end
`ifdef SPI_SCLK_GAP_EN
        GAP: begin
          if (cnt_q == hm1_q) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + (DIV_W - 1)'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
